// File: rtl/step_pkg.sv
// step_pkg -- shared definitions for the stepper-motor step sequencer.
//
// Holds the FSM state encoding, both coil phase tables (full-step and
// half-step), the table-length constants and the phase-index width that
// the selected table implies.
//
// Build option: define STEP_HALF_STEP_EN to select the 8-entry half-step
// table; without it the 4-entry full-step table and a 2-bit phase index
// are used.
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } step_state_t;

  localparam int FULL_STEP_LEN = 4;
  localparam int HALF_STEP_LEN = 8;

  // Coil patterns are ordered {A, B, A', B'}; index 0 is the rest position.
  localparam logic [3:0] FULL_STEP_TABLE [FULL_STEP_LEN] = '{
    4'b1100, 4'b0110, 4'b0011, 4'b1001
  };

  localparam logic [3:0] HALF_STEP_TABLE [HALF_STEP_LEN] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  // Both table lengths are powers of two, so the phase index wraps for free
  // when it over- or under-flows its own width.
`ifdef STEP_HALF_STEP_EN
  localparam int         PHASE_LEN          = HALF_STEP_LEN;
  localparam logic [3:0] PHASE_ZERO_PATTERN = HALF_STEP_TABLE[0];
`else
  localparam int         PHASE_LEN          = FULL_STEP_LEN;
  localparam logic [3:0] PHASE_ZERO_PATTERN = FULL_STEP_TABLE[0];
`endif

  localparam int PHASE_W = $clog2(PHASE_LEN);

endpackage

// File: rtl/step_phase_lut.sv
// step_phase_lut -- maps a phase index onto the coil drive pattern.
//
// Ports:
//   phase_idx  in   PHASE_W  current phase index (0 .. PHASE_LEN-1)
//   pattern    out  4        coil pattern {A, B, A', B'} for that index
//
// Build option: STEP_HALF_STEP_EN selects the half-step table, otherwise
// the full-step table is used.
module step_phase_lut
  import step_pkg::*;
(
  input  logic [PHASE_W-1:0] phase_idx,
  output logic [3:0]         pattern
);

  always_comb begin
`ifdef STEP_HALF_STEP_EN
    pattern = HALF_STEP_TABLE[phase_idx];
`else
    pattern = FULL_STEP_TABLE[phase_idx];
`endif
  end

endmodule

// File: rtl/step_sequencer.sv
// step_sequencer -- stepper-motor phase sequencer.
//
// Moves the motor by a requested number of steps in a requested direction,
// taking one step per upstream tick pulse, and tracks absolute position.
//
// Parameters:
//   STEPS_W    width of the step-count and position fields
//   IDLE_HOLD  1 keeps the coils energised while idle, 0 drops them to 0000
//
// Ports:
//   sclk   in   1        system clock, rising edge
//   rst    in   1        asynchronous active-high reset
//   tick   in   1        step-rate pulse, acted on only while running
//   start  in   1        move request, acted on only while idle
//   dir    in   1        1 = forward, 0 = reverse (sampled with start)
//   steps  in   STEPS_W  number of steps to move (sampled with start)
//   stop   in   1        abort the current move
//   coil   out  4        registered coil drive pattern {A, B, A', B'}
//   busy   out  1        high while a move is running
//   done   out  1        one-cycle pulse at move completion or abort
//   pos    out  STEPS_W  signed position, wraps modulo 2^STEPS_W
//
// Build option: define STEP_HALF_STEP_EN for half-step drive (8-entry
// table); the default build uses full-step drive (4-entry table).
module step_sequencer
  import step_pkg::*;
#(
  parameter int STEPS_W   = 16,
  parameter bit IDLE_HOLD = 1'b1
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               dir,
  input  logic [STEPS_W-1:0] steps,
  input  logic               stop,
  output logic [3:0]         coil,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] pos
);

  step_state_t        state, state_n;
  logic [PHASE_W-1:0] phase_idx, phase_n;
  logic [STEPS_W-1:0] remaining, remaining_n;
  logic [STEPS_W-1:0] pos_n;
  logic               dir_q, dir_n;
  logic [3:0]         next_pattern;

  // The pattern is looked up from the next phase index so that the
  // registered coil output shows a new step right after the tick edge.
  step_phase_lut u_lut (
    .phase_idx (phase_n),
    .pattern   (next_pattern)
  );

  // Next-state logic: stop wins over tick, and a step that consumes the
  // last remaining count heads straight for FINISH.
  always_comb begin
    state_n     = state;
    phase_n     = phase_idx;
    remaining_n = remaining;
    pos_n       = pos;
    dir_n       = dir_q;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (steps != '0) begin
            remaining_n = steps;
            dir_n       = dir;
            state_n     = ST_RUN;
          end else begin
            state_n = ST_FINISH;
          end
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_n = ST_FINISH;
        end else if (tick) begin
          if (dir_q) begin
            phase_n = phase_idx + PHASE_W'(1);
            pos_n   = pos + STEPS_W'(1);
          end else begin
            phase_n = phase_idx - PHASE_W'(1);
            pos_n   = pos - STEPS_W'(1);
          end
          remaining_n = remaining - STEPS_W'(1);
          if (remaining == STEPS_W'(1)) begin
            state_n = ST_FINISH;
          end
        end
      end

      ST_FINISH: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs. busy/done/coil are derived
  // from the next state so they line up with the state register.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase_idx <= '0;
      remaining <= '0;
      pos       <= '0;
      dir_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      coil      <= IDLE_HOLD ? PHASE_ZERO_PATTERN : 4'b0000;
    end else begin
      state     <= state_n;
      phase_idx <= phase_n;
      remaining <= remaining_n;
      pos       <= pos_n;
      dir_q     <= dir_n;
      busy      <= (state_n == ST_RUN);
      done      <= (state_n == ST_FINISH);
      coil      <= (IDLE_HOLD || (state_n == ST_RUN)) ? next_pattern : 4'b0000;
    end
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEPS_W, default 16, width of step-count and position fields.
REQ-002 SHALL have parameter IDLE_HOLD, default 1; 1 keeps coils energised in IDLE, 0 drives coil = 4'b0000 in IDLE.
REQ-003 sclk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle step-rate pulse from the upstream pulse generator.
REQ-006 start  input  1  one-cycle move request, sampled in IDLE only.
REQ-007 dir  input  1  1 = forward (phase index +1), 0 = reverse (phase index -1); sampled with start.
REQ-008 steps  input  STEPS_W  number of steps to move; sampled with start.
REQ-009 stop  input  1  abort current move.
REQ-010 coil  output  4  registered coil drive pattern {A, B, A', B'}.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse at move completion or abort.
REQ-013 pos  output  STEPS_W  signed position counter, wraps modulo 2^STEPS_W.

Function
REQ-014 SHALL implement states IDLE, RUN and FINISH.
REQ-015 IDLE: start=1 with steps!=0 SHALL latch steps into a remaining counter, latch dir, and enter RUN next cycle.
REQ-016 IDLE: start=1 with steps==0 SHALL go to FINISH without changing the phase or pos.
REQ-017 RUN: each cycle with tick=1 and stop=0 SHALL advance the phase index by ±1 modulo table length, decrement remaining, and change pos by ±1.
REQ-018 RUN: a step that brings remaining to 0 SHALL be followed by FINISH on the next cycle.
REQ-019 RUN: stop=1 SHALL enter FINISH next cycle and take no step that cycle, even if tick=1.
REQ-020 FINISH SHALL assert done for exactly one cycle and then return to IDLE.
REQ-021 start in RUN or FINISH SHALL be ignored; tick in IDLE or FINISH SHALL be ignored.
REQ-022 coil SHALL reflect the new phase index one sclk cycle after the tick that caused the step.
REQ-023 busy SHALL be 1 exactly while the state is RUN.
REQ-024 Phase index and pos SHALL persist across moves; only reset clears them.
REQ-025 With IDLE_HOLD=0, coil SHALL be 0 in IDLE and FINISH, and SHALL be the table value in RUN.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, phase index 0, remaining 0, pos 0, busy 0 and done 0.
REQ-027 During reset, coil SHALL be the table entry 0 if IDLE_HOLD=1, and 4'b0000 if IDLE_HOLD=0.
REQ-028 Reset mid-move SHALL abandon the move without a done pulse.

Configuration
REQ-029 Macro STEP_HALF_STEP_EN, when defined, SHALL select the 8-entry half-step table 1000,1100,0100,0110,0010,0011,0001,1001 (index 0..7).
REQ-030 Without the macro, the 4-entry full-step table 1100,0110,0011,1001 (index 0..3) SHALL be used, with a 2-bit phase index.
REQ-031 pos SHALL count table steps in both modes.

Structure
REQ-032 Shared package step_pkg SHALL hold the state encoding, both phase tables and the table-length constants.
REQ-033 Sub-module step_phase_lut SHALL map phase index to the coil pattern, selecting its table by macro.
REQ-034 The top level SHALL contain the FSM, the counters and the output register.

Verification
REQ-035 Full-step build: reset, then start with steps=3, dir=1, and ticks every 10 cycles -> coil 1100→0110→0011→1001, pos=3, busy high for the move, one done pulse.
REQ-036 From pos=3, steps=5 with dir=0 -> pos=-2 (16'hFFFE); the phase index wraps through 0 backwards.
REQ-037 stop asserted in the same cycle as the 2nd tick of a 4-step move -> only 1 step taken, done one cycle later, pos=+1.
REQ-038 start with steps=0 -> done pulses 1 cycle after start, busy never rises, coil and pos unchanged.
REQ-039 Half-step build: 9 forward ticks -> coil sequence wraps back to 1000 then 1100; rst asserted mid-move -> coil=1000, pos=0, no done pulse.
REQ-040 IDLE_HOLD=0: coil=0000 before the move, the table pattern during RUN, 0000 after done; start pulses during RUN have no effect.
